i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter: ADDR, 7'h50, 7-bit target address matched against the address phase.
REQ-002 SHALL have port: clk  input  1  system clock; must run at least 20x the SCL frequency.
REQ-003 SHALL have port: reset_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: sda_i  input  1  bus SDA level (asynchronous).
REQ-005 SHALL have port: scl_i  input  1  bus SCL level (asynchronous).
REQ-006 SHALL have port: sda_o  output  1  open-drain SDA drive; 0 = pull low, 1 = release.
REQ-007 SHALL have port: scl_o  output  1  open-drain SCL drive; 0 = clock stretch, 1 = release.
REQ-008 SHALL have port: rx_data  output  8  last byte received in a master-write.
REQ-009 SHALL have port: rx_valid  output  1  one-clk pulse; rx_data updated this cycle.
REQ-010 SHALL have port: tx_req  output  1  level; core is stretching SCL and waiting for a read byte.
REQ-011 SHALL have port: tx_data  input  8  byte to transmit; sampled when tx_valid & tx_req.
REQ-012 SHALL have port: tx_valid  input  1  local side offers tx_data.
REQ-013 SHALL have port: busy  output  1  high from address match until STOP, NACK or mismatch.
REQ-014 SHALL have port: rw  output  1  R/W bit of the last matched address; 1 = master read.
REQ-015 SHALL have port: start_det  output  1  one-clk pulse on START or repeated START.
REQ-016 SHALL have port: stop_det  output  1  one-clk pulse on STOP.
REQ-017 SHALL have port: nack_rcvd  output  1  one-clk pulse when the master NACKs a read byte.

Function
REQ-018 SHALL pass sda_i and scl_i through 2-FF synchronizers and derive SCL rise/fall pulses from the synchronized values.
REQ-019 SHALL detect START as synchronized SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-020 SHALL implement states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX_WAIT, TX, TX_ACK.
REQ-021 SHALL, on START in any state, pulse start_det, release sda_o and scl_o, clear the bit counter, and enter ADDR.
REQ-022 SHALL, on STOP in any state, pulse stop_det, release both lines, clear busy, and enter IDLE.
REQ-023 SHALL sample SDA only on SCL rise and change sda_o only on SCL fall; bytes are MSB first.
REQ-024 SHALL, in ADDR after the 8th rise, compare bits[7:1] to ADDR: on match set busy and rw=bit0 and enter ADDR_ACK; on mismatch enter IDLE with sda_o=1 until the next START.
REQ-025 SHALL, in ADDR_ACK, drive sda_o=0 from the next SCL fall to the following SCL fall, then enter RX (rw=0) or TX_WAIT (rw=1).
REQ-026 SHALL, in RX on the 8th rise, update rx_data, pulse rx_valid one clk later at most, and enter RX_ACK; every received byte SHALL be ACKed (sda_o=0 for one SCL low-high-low window).
REQ-027 SHALL, in TX_WAIT, hold scl_o=0 and tx_req=1; on tx_valid & tx_req it SHALL latch tx_data, drive its MSB on sda_o, then release scl_o and drop tx_req in the next clk.
REQ-028 SHALL, in TX, shift the next bit onto sda_o at each SCL fall; after the 8th bit's fall it SHALL release sda_o and enter TX_ACK.
REQ-029 SHALL, in TX_ACK on SCL rise: if SDA=0, enter TX_WAIT at the next SCL fall; if SDA=1, pulse nack_rcvd, clear busy, release lines, and enter IDLE.
REQ-030 SHALL give START/STOP priority over a simultaneous SCL edge or tx_valid in the same clk.
REQ-031 SHALL ignore tx_valid when tx_req=0, and SHALL NOT update rx_data on an incomplete byte that is aborted by START/STOP.
REQ-032 SHALL keep scl_o=1 in all states except TX_WAIT.

Reset
REQ-033 SHALL, while reset_n=0, force: state IDLE, sda_o=1, scl_o=1, rx_data=0, rw=0, busy=0, and tx_req/rx_valid/start_det/stop_det/nack_rcvd=0.
REQ-034 SHALL release both bus lines immediately, asynchronously, on reset assertion mid-transfer, and SHALL ignore the bus until a fresh START after release.

Verification
REQ-035 SHALL cover: START, 0xA0, 0x3C, STOP -> two ACKs on sda_o; rx_valid once with rx_data=0x3C; busy=1 then 0; stop_det pulse.
REQ-036 SHALL cover: START, 0xA2 (mismatch) -> no ACK (sda_o=1 throughout); busy=0; no rx_valid.
REQ-037 SHALL cover: START, 0xA1, tx_valid held off for 50 clk -> scl_o=0 and tx_req=1 for 50 clk; after tx_data=0x96, bits 1,0,0,1,0,1,1,0 appear on sda_o.
REQ-038 SHALL cover: master read of two bytes with ACK then NACK -> tx_req asserted twice; nack_rcvd pulse; state returns to IDLE.
REQ-039 SHALL cover: START, 0xA0, 4 data bits, then repeated START, 0xA1 -> start_det twice; no rx_valid; rw=1.
REQ-040 SHALL cover: reset_n asserted during TX_WAIT -> sda_o=1, scl_o=1, tx_req=0 without waiting for a clk edge.

Source files
------------

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target: fixed 7-bit address, byte-wide receive and transmit handshake
module i2c_slave #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sda_i,
    input  logic       scl_i,
    output logic       sda_o,
    output logic       scl_o,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       busy,
    output logic       rw,
    output logic       start_det,
    output logic       stop_det,
    output logic       nack_rcvd
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX_WAIT, S_TX, S_TX_ACK
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] sda_pipe_q, sda_pipe_d, scl_pipe_q, scl_pipe_d;
    logic [1:0] settle_q, settle_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
    logic       sda_o_q, sda_o_d, scl_o_q, scl_o_d;
    logic       rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
    logic       busy_q, busy_d, rw_q, rw_d;
    logic       start_det_q, start_det_d, stop_det_q, stop_det_d, nack_q, nack_d;
    logic       sda_s, scl_s, live, scl_rise, scl_fall, start_c, stop_c;

    // pipe[0]/[1] form the synchronizer, pipe[2] is the previous synchronized level
    assign sda_s    = sda_pipe_q[1];
    assign scl_s    = scl_pipe_q[1];
    // edges are ignored until the pipes hold real bus levels after reset
    assign live     = (settle_q == 2'd3);
    assign scl_rise = live & scl_s & ~scl_pipe_q[2];
    assign scl_fall = live & ~scl_s & scl_pipe_q[2];
    assign start_c  = live & scl_s & scl_pipe_q[2] & sda_pipe_q[2] & ~sda_s;
    assign stop_c   = live & scl_s & scl_pipe_q[2] & ~sda_pipe_q[2] & sda_s;

    always_comb begin
        state_d     = state_q;
        sda_pipe_d  = {sda_pipe_q[1:0], sda_i};
        scl_pipe_d  = {scl_pipe_q[1:0], scl_i};
        settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        sda_o_d     = sda_o_q;
        busy_d      = busy_q;
        rw_d        = rw_q;
        rx_valid_d  = 1'b0;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        nack_d      = 1'b0;

        if (start_c) begin
            start_det_d = 1'b1;
            sda_o_d     = 1'b1;
            bit_cnt_d   = 4'd0;
            state_d     = S_ADDR;
        end else if (stop_c) begin
            stop_det_d = 1'b1;
            sda_o_d    = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        if (shift_d[7:1] == ADDR) begin
                            busy_d  = 1'b1;
                            rw_d    = shift_d[0];
                            state_d = S_ADDR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end
                // sda_o itself marks the ACK phase: released on entry, low once the window opens
                S_ADDR_ACK, S_RX_ACK: if (scl_fall) begin
                    if (sda_o_q) begin
                        sda_o_d = 1'b0;
                    end else begin
                        sda_o_d   = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = (state_q == S_RX_ACK || !rw_q) ? S_RX : S_TX_WAIT;
                    end
                end
                S_RX: if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        rx_data_d  = shift_d;
                        rx_valid_d = 1'b1;
                        state_d    = S_RX_ACK;
                    end
                end
                S_TX_WAIT: if (tx_valid && tx_req_q) begin
                    shift_d   = tx_data;
                    sda_o_d   = tx_data[7];
                    bit_cnt_d = 4'd0;
                    state_d   = S_TX;
                end
                S_TX: if (scl_fall) begin
                    if (bit_cnt_q == 4'd7) begin
                        sda_o_d   = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = S_TX_ACK;
                    end else begin
                        sda_o_d   = shift_q[6];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                // bit_cnt == 1 records that the master ACKed; leave on the closing fall
                S_TX_ACK: if (scl_rise) begin
                    if (!sda_s) begin
                        bit_cnt_d = 4'd1;
                    end else begin
                        nack_d  = 1'b1;
                        busy_d  = 1'b0;
                        sda_o_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (scl_fall && bit_cnt_q == 4'd1) begin
                    bit_cnt_d = 4'd0;
                    state_d   = S_TX_WAIT;
                end
                default: ;
            endcase
        end

        tx_req_d = (state_d == S_TX_WAIT);
        scl_o_d  = (state_d != S_TX_WAIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sda_pipe_q  <= 3'b111;
            scl_pipe_q  <= 3'b111;
            settle_q    <= 2'd0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            sda_o_q     <= 1'b1;
            scl_o_q     <= 1'b1;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            nack_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sda_pipe_q  <= sda_pipe_d;
            scl_pipe_q  <= scl_pipe_d;
            settle_q    <= settle_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            sda_o_q     <= sda_o_d;
            scl_o_q     <= scl_o_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
            nack_q      <= nack_d;
        end
    end

    assign sda_o     = sda_o_q;
    assign scl_o     = scl_o_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign busy      = busy_q;
    assign rw        = rw_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;
    assign nack_rcvd = nack_q;
endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - bus-level bench for i2c_slave with open-drain master model and byte scoreboard
module tb_i2c_slave;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sda_m, scl_m, sda_line, scl_line;
    logic       sda_o, scl_o, rx_valid, tx_req, tx_valid, busy, rw;
    logic       start_det, stop_det, nack_rcvd;
    logic [7:0] rx_data, tx_data;

    assign sda_line = sda_m & sda_o;
    assign scl_line = scl_m & scl_o;

    i2c_slave #(.ADDR(7'h50)) dut (
        .clk(clk), .reset_n(reset_n), .sda_i(sda_line), .scl_i(scl_line),
        .sda_o(sda_o), .scl_o(scl_o), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_req(tx_req), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy),
        .rw(rw), .start_det(start_det), .stop_det(stop_det), .nack_rcvd(nack_rcvd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       exp_ack;
    } wr_vec_t;

    int         n_checks = 0, n_errors = 0;
    int         rx_cnt = 0, rx_rd = 0, start_cnt = 0, stop_cnt = 0, nack_cnt = 0;
    int         txreq_rise_cnt = 0, sda_low_cnt = 0;
    logic       txreq_prev = 1'b0;
    logic [7:0] rx_log [64];
    logic [7:0] exp_rx [$];
    logic [7:0] exp_tx [$];

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt % 64] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (start_det) start_cnt <= start_cnt + 1;
        if (stop_det) stop_cnt <= stop_cnt + 1;
        if (nack_rcvd) nack_cnt <= nack_cnt + 1;
        if (!sda_o) sda_low_cnt <= sda_low_cnt + 1;
        txreq_prev <= tx_req;
        if (tx_req && !txreq_prev) txreq_rise_cnt <= txreq_rise_cnt + 1;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_scl_high();
        int t = 0;
        while (!scl_line && t < 300) begin
            tick(1);
            t++;
        end
        check("scl_released", scl_line, 1);
    endtask

    task automatic wait_tx_req();
        int t = 0;
        while (!tx_req && t < 300) begin
            tick(1);
            t++;
        end
        check("tx_req_seen", tx_req, 1);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; wait_scl_high(); tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; wait_scl_high(); tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic xfer_bit(input logic b, output logic got);
        sda_m = b; tick(Q);
        scl_m = 1'b1; wait_scl_high(); tick(Q);
        got = sda_line;
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic g;
        for (int i = 7; i >= 0; i--) xfer_bit(d[i], g);
        xfer_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        logic g;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, g);
            d[i] = g;
        end
        xfer_bit(ack_bit, g);
    endtask

    task automatic supply_tx(input logic [7:0] d);
        exp_tx.push_back(d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        check("tx_req_drop", tx_req, 0);
        check("scl_release_after_tx", scl_o, 1);
        tx_valid = 1'b0;
    endtask

    task automatic read_and_score(input logic ack_bit);
        logic [7:0] d;
        logic [7:0] e;
        read_byte(ack_bit, d);
        e = exp_tx.pop_front();
        check("tx_byte_on_sda", d, e);
    endtask

    task automatic drain_rx(input string nm);
        check("rx_valid_count", rx_cnt, rx_rd + exp_rx.size());
        while (exp_rx.size() > 0 && rx_rd < rx_cnt) begin
            check(nm, rx_log[rx_rd % 64], exp_rx.pop_front());
            rx_rd++;
        end
        exp_rx.delete();
        rx_rd = rx_cnt;
    endtask

    task automatic run_write(input wr_vec_t v);
        logic ack;
        int   s0, p0, l0;
        s0 = start_cnt; p0 = stop_cnt; l0 = sda_low_cnt;
        bus_start();
        write_byte(v.addr, ack);
        check("addr_ack", ack, v.exp_ack ? 0 : 1);
        check("busy_after_addr", busy, v.exp_ack);
        if (v.exp_ack) begin
            check("rw_write", rw, 0);
            exp_rx.push_back(v.data);
        end
        write_byte(v.data, ack);
        check("data_ack", ack, v.exp_ack ? 0 : 1);
        bus_stop();
        tick(4);
        drain_rx("rx_data");
        check("busy_after_stop", busy, 0);
        check("stop_det_count", stop_cnt - p0, 1);
        check("start_det_count", start_cnt - s0, 1);
        if (!v.exp_ack) check("sda_never_low", sda_low_cnt - l0, 0);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_vec_t vecs [6];
        logic    ack;
        int      s0, r0, n0, t0, bad;

        vecs[0] = '{addr: 8'hA0, data: 8'h3C, exp_ack: 1'b1};
        vecs[1] = '{addr: 8'hA2, data: 8'h55, exp_ack: 1'b0};
        vecs[2] = '{addr: 8'hA0, data: 8'h00, exp_ack: 1'b1};
        vecs[3] = '{addr: 8'hA0, data: 8'hFF, exp_ack: 1'b1};
        vecs[4] = '{addr: 8'h20, data: 8'h81, exp_ack: 1'b0};
        vecs[5] = '{addr: 8'hA0, data: 8'hA5, exp_ack: 1'b1};

        reset_n = 1'b0; sda_m = 1'b1; scl_m = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        tick(3);
        check("rst_sda_o", sda_o, 1);
        check("rst_scl_o", scl_o, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rw", rw, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {tx_req, rx_valid, start_det, stop_det, nack_rcvd}, 0);
        reset_n = 1'b1;
        tick(5);

        for (int i = 0; i < 6; i++) run_write(vecs[i]);

        // read with 50-clk hold-off, single byte then NACK
        n0 = nack_cnt;
        bus_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", ack, 0);
        check("rw_read", rw, 1);
        wait_tx_req();
        sda_m = 1'b1; scl_m = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (scl_o !== 1'b0 || tx_req !== 1'b1 || scl_line !== 1'b0) bad++;
        end
        check("stretch_50_clk", bad, 0);
        supply_tx(8'h96);
        read_and_score(1'b1);
        tick(4);
        check("nack_single", nack_cnt - n0, 1);
        check("busy_after_nack", busy, 0);
        bus_stop();

        // two-byte read: ACK then NACK
        n0 = nack_cnt; t0 = txreq_rise_cnt;
        bus_start();
        write_byte(8'hA1, ack);
        check("rd2_addr_ack", ack, 0);
        wait_tx_req();
        supply_tx(8'hC3);
        read_and_score(1'b0);
        wait_tx_req();
        supply_tx(8'h5A);
        read_and_score(1'b1);
        tick(4);
        check("rd2_nack", nack_cnt - n0, 1);
        check("rd2_tx_req_twice", txreq_rise_cnt - t0, 2);
        check("rd2_busy", busy, 0);
        bus_stop();
        tick(4);
        check("rd2_idle_lines", {sda_o, scl_o, tx_req}, 3'b110);

        // partial write aborted by repeated START, then read address
        s0 = start_cnt; r0 = rx_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check("rs_addr_ack", ack, 0);
        xfer_bit(1'b1, ack); xfer_bit(1'b0, ack); xfer_bit(1'b1, ack); xfer_bit(1'b1, ack);
        bus_start();
        write_byte(8'hA1, ack);
        check("rs_read_ack", ack, 0);
        check("rs_start_twice", start_cnt - s0, 2);
        check("rs_no_rx_valid", rx_cnt - r0, 0);
        check("rs_rw", rw, 1);

        // asynchronous reset while stretching in TX_WAIT
        wait_tx_req();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_sda", sda_o, 1);
        check("async_rst_scl", scl_o, 1);
        check("async_rst_tx_req", tx_req, 0);
        check("async_rst_busy", busy, 0);
        tick(2);
        reset_n = 1'b1;
        scl_m = 1'b1; sda_m = 1'b1;
        tick(20);
        check("post_rst_idle", {busy, tx_req, scl_o, sda_o}, 4'b0011);
        rx_rd = rx_cnt;
        run_write('{addr: 8'hA0, data: 8'h5A, exp_ack: 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
